// File: rtl/canny_pkg.sv
// canny_pkg - definitions shared across the Canny edge pipeline.
//   DIR_*        : 2-bit quantised gradient directions (shared with the direction quantiser)
//   nms_state_t  : frame-tracking state of the non-maximum suppression stage
package canny_pkg;

    localparam logic [1:0] DIR_0   = 2'd0;
    localparam logic [1:0] DIR_45  = 2'd1;
    localparam logic [1:0] DIR_90  = 2'd2;
    localparam logic [1:0] DIR_135 = 2'd3;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } nms_state_t;

endpackage

// File: rtl/grad_nms_3x3_if.sv
// grad_nms_3x3_if - window-in / thinned-pixel-out bundle of the NMS stage.
//   master : upstream window generator + downstream consumer (drives window, reads result)
//   slave  : grad_nms_3x3 (reads window, drives result)
//   sof, win_valid, p11..p33, dir  : frame restart, window valid, 3x3 window, centre direction
//   nms_valid, nms_mag, pix_x, pix_y, frame_done : thinned output and its coordinates
interface grad_nms_3x3_if #(
    parameter int DATA_WIDTH = 16,
    parameter int XW         = 9,
    parameter int YW         = 10
);
    logic                  sof;
    logic                  win_valid;
    logic [DATA_WIDTH-1:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
    logic [1:0]            dir;
    logic                  nms_valid;
    logic [DATA_WIDTH-1:0] nms_mag;
    logic [XW-1:0]         pix_x;
    logic [YW-1:0]         pix_y;
    logic                  frame_done;

    modport master (
        output sof, win_valid, p11, p12, p13, p21, p22, p23, p31, p32, p33, dir,
        input  nms_valid, nms_mag, pix_x, pix_y, frame_done
    );

    modport slave (
        input  sof, win_valid, p11, p12, p13, p21, p22, p23, p31, p32, p33, dir,
        output nms_valid, nms_mag, pix_x, pix_y, frame_done
    );
endinterface

// File: rtl/nms_nbr_sel.sv
// nms_nbr_sel - picks the two neighbours lying along the gradient direction.
//   p11_i..p33_i : 3x3 window less the centre
//   dir_i        : quantised direction (DIR_0/45/90/135)
//   na_o, nb_o   : neighbour on the "A" side (ties kept) and "B" side (ties suppressed)
module nms_nbr_sel
    import canny_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] p11_i, p12_i, p13_i,
    input  logic [DATA_WIDTH-1:0] p21_i,        p23_i,
    input  logic [DATA_WIDTH-1:0] p31_i, p32_i, p33_i,
    input  logic [1:0]            dir_i,
    output logic [DATA_WIDTH-1:0] na_o,
    output logic [DATA_WIDTH-1:0] nb_o
);
    always_comb begin
        na_o = p21_i;
        nb_o = p23_i;
        case (dir_i)
            DIR_0:   begin na_o = p21_i; nb_o = p23_i; end
            DIR_45:  begin na_o = p13_i; nb_o = p31_i; end
            DIR_90:  begin na_o = p12_i; nb_o = p32_i; end
            DIR_135: begin na_o = p11_i; nb_o = p33_i; end
            default: ;
        endcase
    end
endmodule

// File: rtl/grad_nms_3x3.sv
// grad_nms_3x3 - Canny non-maximum suppression on a 3x3 gradient-magnitude window.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : grad_nms_3x3_if slave (window in, thinned magnitude + coordinates out)
// Two register stages: stage 1 captures centre, selected neighbours, border/last
// flags and coordinates; stage 2 produces the thinned output. Fixed 2-cycle latency.
// Build option: define NMS_THRESH_EN to also zero centres below LOW_TH.
module grad_nms_3x3
    import canny_pkg::*;
#(
    parameter int                    WIDTH      = 512,
    parameter int                    DEPTH      = 638,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] LOW_TH     = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    grad_nms_3x3_if.slave bus
);
    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] c;
        logic [DATA_WIDTH-1:0] na;
        logic [DATA_WIDTH-1:0] nb;
        logic                  border;
        logic                  last;
        logic [XW-1:0]         x;
        logic [YW-1:0]         y;
    } s1_t;

    logic [DATA_WIDTH-1:0] na, nb;
    logic [XW-1:0]         col_q, col_d;
    logic [YW-1:0]         row_q, row_d;
    logic                  col_end, row_end, last, border;
    nms_state_t            state_q;
    s1_t                   s1_q;
    logic [1:0]            vld_pipe_q;   // [0] stage 1, [1] stage 2 (= nms_valid)
    logic [DATA_WIDTH-1:0] mag_q;
    logic [XW-1:0]         pix_x_q;
    logic [YW-1:0]         pix_y_q;
    logic                  frame_done_q;
    logic                  keep, th_ok;

    nms_nbr_sel #(.DATA_WIDTH(DATA_WIDTH)) u_sel (
        .p11_i (bus.p11), .p12_i (bus.p12), .p13_i (bus.p13),
        .p21_i (bus.p21),                   .p23_i (bus.p23),
        .p31_i (bus.p31), .p32_i (bus.p32), .p33_i (bus.p33),
        .dir_i (bus.dir),
        .na_o  (na),
        .nb_o  (nb)
    );

    assign col_end = (col_q == XW'(WIDTH - 1));
    assign row_end = (row_q == YW'(DEPTH - 1));
    assign last    = col_end && row_end;
    assign border  = (col_q == '0) || col_end || (row_q == '0) || row_end;
    assign col_d   = col_end ? '0 : col_q + 1'b1;
    assign row_d   = !col_end ? row_q : (row_end ? '0 : row_q + 1'b1);

    // >= on A, > on B: exactly one pixel of a flat ridge survives.
    assign keep = (s1_q.c >= s1_q.na) && (s1_q.c > s1_q.nb);

`ifdef NMS_THRESH_EN
    assign th_ok = (s1_q.c >= LOW_TH);
`else
    assign th_ok = 1'b1;
    wire unused_low_th = ^LOW_TH;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            state_q      <= IDLE;
            s1_q         <= '0;
            vld_pipe_q   <= '0;
            mag_q        <= '0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            frame_done_q <= 1'b0;
        end else if (bus.sof) begin
            // Frame restart wins over a coincident window, which is dropped.
            col_q        <= '0;
            row_q        <= '0;
            state_q      <= IDLE;
            s1_q         <= '0;
            vld_pipe_q   <= '0;
            mag_q        <= '0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[0], bus.win_valid};
            if (bus.win_valid) begin
                s1_q  <= '{c: bus.p22, na: na, nb: nb, border: border,
                           last: last, x: col_q, y: row_q};
                col_q <= col_d;
                row_q <= row_d;
                // The window arriving in IDLE is itself accepted.
                case (state_q)
                    IDLE:    state_q <= last ? IDLE : ACTIVE;
                    ACTIVE:  state_q <= last ? IDLE : ACTIVE;
                    default: state_q <= IDLE;
                endcase
            end
            mag_q        <= (vld_pipe_q[0] && keep && !s1_q.border && th_ok) ? s1_q.c : '0;
            pix_x_q      <= vld_pipe_q[0] ? s1_q.x : '0;
            pix_y_q      <= vld_pipe_q[0] ? s1_q.y : '0;
            frame_done_q <= vld_pipe_q[0] && s1_q.last;
        end
    end

    assign bus.nms_valid  = vld_pipe_q[1];
    assign bus.nms_mag    = mag_q;
    assign bus.pix_x      = pix_x_q;
    assign bus.pix_y      = pix_y_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_grad_nms_3x3.sv
// tb_grad_nms_3x3 - directed self-checking bench for grad_nms_3x3 (8x6 frame, 16-bit).
module tb_grad_nms_3x3;
    localparam int          W   = 8;
    localparam int          D   = 6;
    localparam int          DW  = 16;
    localparam logic [15:0] LTH = 16'd30;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    grad_nms_3x3_if #(.DATA_WIDTH(DW), .XW(3), .YW(3)) bus ();

    grad_nms_3x3 #(.WIDTH(W), .DEPTH(D), .DATA_WIDTH(DW), .LOW_TH(LTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int ex = 0;
    int ey = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_win(input logic [15:0] p11, p12, p13, p21, p22, p23, p31, p32, p33,
                           input logic [1:0] d);
        bus.p11 = p11; bus.p12 = p12; bus.p13 = p13;
        bus.p21 = p21; bus.p22 = p22; bus.p23 = p23;
        bus.p31 = p31; bus.p32 = p32; bus.p33 = p33;
        bus.dir = d;
    endtask

    task automatic bump();
        ex++;
        if (ex == W) begin
            ex = 0;
            ey++;
            if (ey == D) ey = 0;
        end
    endtask

    // One isolated window: drive at a negedge, check the result two edges later.
    task automatic step(input string tag, input logic [15:0] exp_mag);
        bus.win_valid = 1'b1;
        @(negedge clk);
        bus.win_valid = 1'b0;
        chk({tag, "_gap"}, bus.nms_valid, 0);
        @(negedge clk);
        chk({tag, "_vld"}, bus.nms_valid, 1);
        chk({tag, "_mag"}, bus.nms_mag, exp_mag);
        chk({tag, "_x"}, bus.pix_x, ex);
        chk({tag, "_y"}, bus.pix_y, ey);
        chk({tag, "_fd"}, bus.frame_done, (ex == W - 1 && ey == D - 1) ? 1 : 0);
        bump();
        set_win(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
    endtask

    task automatic advance_to(input int x, input int y);
        int guard = 0;
        while (!(ex == x && ey == y) && guard < 100) begin
            set_win(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
            step("fill", 16'd0);
            guard++;
        end
        chk("adv_bound", (guard < 100) ? 1 : 0, 1);
    endtask

    initial begin
        int          sent, outs, fds, sx, sy;
        logic [1:0]  vh;
        logic [15:0] mh [2];
        logic        nv;
        logic [15:0] c;

        bus.sof = 1'b0;
        bus.win_valid = 1'b0;
        set_win(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);

        // Reset state
        #1;
        chk("rst_vld", bus.nms_valid, 0);
        chk("rst_mag", bus.nms_mag, 0);
        chk("rst_x", bus.pix_x, 0);
        chk("rst_y", bus.pix_y, 0);
        chk("rst_fd", bus.frame_done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Async reset mid-stream
        step("pre", 16'd0);
        step("pre", 16'd0);
        bus.win_valid = 1'b1;            // pixel (2,0)
        @(negedge clk);                  // pixel (3,0) also in flight
        @(negedge clk);
        bus.win_valid = 1'b0;
        chk("midrst_pre_vld", bus.nms_valid, 1);
        chk("midrst_pre_x", bus.pix_x, 2);
        rst_n = 1'b0;
        #1;
        chk("midrst_vld", bus.nms_valid, 0);
        chk("midrst_x", bus.pix_x, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ex = 0; ey = 0;
        chk("midrst_flush", bus.nms_valid, 0);
        step("post_rst", 16'd0);         // must report (0,0)

        // Interior local maximum along dir 0, then suppressed
        advance_to(3, 2);
        set_win(0, 0, 0, 10, 20, 15, 0, 0, 0, 2'd0);
        step("int_max", 16'd20);
        set_win(0, 0, 0, 10, 20, 25, 0, 0, 0, 2'd0);
        step("int_sup", 16'd0);

        // Flat ridge along dir 90
        set_win(0, 20, 0, 0, 20, 0, 0, 20, 0, 2'd2);
        step("tie_eq", 16'd0);
        set_win(0, 20, 0, 0, 20, 0, 0, 19, 0, 2'd2);
        step("tie_lt", 16'd20);

        // Diagonal directions
        advance_to(1, 3);
        set_win(5, 0, 9, 0, 7, 0, 3, 0, 8, 2'd1);   // dir45: 7>=9? no
        step("d45", 16'd0);
        set_win(5, 0, 9, 0, 7, 0, 3, 0, 6, 2'd3);   // dir135: 7>=5 && 7>6
        step("d135", 16'd7);

        // Borders
        advance_to(7, 3);
        set_win(0, 0, 0, 0, 100, 0, 0, 0, 0, 2'd0);
        step("bord_c7", 16'd0);
        set_win(0, 0, 0, 0, 100, 0, 0, 0, 0, 2'd0);
        step("bord_c0", 16'd0);
        advance_to(3, 5);
        set_win(0, 0, 0, 0, 100, 0, 0, 0, 0, 2'd0);
        step("bord_r5", 16'd0);
        advance_to(3, 0);                 // passes (7,5): frame_done checked in step
        set_win(0, 0, 0, 0, 100, 0, 0, 0, 0, 2'd0);
        step("bord_r0", 16'd0);

        // Low threshold (build-dependent)
        advance_to(3, 1);
        set_win(0, 0, 0, 0, 25, 0, 0, 0, 0, 2'd0);
`ifdef NMS_THRESH_EN
        step("th_25", 16'd0);
`else
        step("th_25", 16'd25);
`endif
        set_win(0, 0, 0, 0, 30, 0, 0, 0, 0, 2'd0);
        step("th_30", 16'd30);

        // Full streamed frame with random gaps, after sof
        @(negedge clk);
        bus.sof = 1'b1;
        @(negedge clk);
        bus.sof = 1'b0;
        ex = 0; ey = 0;
        sent = 0; outs = 0; fds = 0;
        vh = 2'b00; mh[0] = '0; mh[1] = '0;
        for (int cyc = 0; cyc < 400 && outs < 48; cyc++) begin
            chk("ff_vld", bus.nms_valid, vh[1]);
            if (vh[1]) begin
                chk("ff_x", bus.pix_x, ex);
                chk("ff_y", bus.pix_y, ey);
                chk("ff_mag", bus.nms_mag, mh[1]);
                chk("ff_fd", bus.frame_done, (ex == W - 1 && ey == D - 1) ? 1 : 0);
                if (bus.frame_done) fds++;
                bump();
                outs++;
            end else begin
                chk("ff_fd_idle", bus.frame_done, 0);
            end
            nv = (sent < 48) && ($urandom_range(0, 2) != 0);
            mh[1] = mh[0];
            mh[0] = '0;
            set_win(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'(($urandom_range(0, 3))));
            if (nv) begin
                c  = 16'($urandom_range(1, 1000));
                sx = sent % W;
                sy = sent / W;
                bus.p22 = c;
                mh[0] = (sx == 0 || sx == W - 1 || sy == 0 || sy == D - 1) ? 16'd0 : c;
                sent++;
            end
            bus.win_valid = nv;
            vh = {vh[0], nv};
            @(negedge clk);
        end
        bus.win_valid = 1'b0;
        chk("ff_outs", outs, 48);
        chk("ff_fd_cnt", fds, 1);

        // sof mid-frame flushes an in-flight window and drops a coincident one
        set_win(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
        advance_to(4, 2);
        bus.win_valid = 1'b1;             // (4,2) enters stage 1
        @(negedge clk);
        bus.sof = 1'b1;                   // coincident window discarded
        bus.p22 = 16'd100;
        @(negedge clk);
        bus.sof = 1'b0;
        bus.win_valid = 1'b0;
        bus.p22 = 16'd0;
        chk("sof_flush", bus.nms_valid, 0);
        @(negedge clk);
        chk("sof_drop", bus.nms_valid, 0);
        ex = 0; ey = 0;
        step("post_sof", 16'd0);          // must report (0,0)

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
